muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit that sits beside the ALU in the execute stage. It consumes the same `porta`/`portb` operand words that feed the ALU and performs the MIPS MULT/MULTU/DIV/DIVU operations over multiple cycles. Results go into the HI/LO architectural registers. The `busy` output stalls the pipeline while an operation is in flight.

---
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU beside the ALU.
// Multiply is shift-add and divide is restoring, one bit per cycle, on
// operand magnitudes. Signs are applied in FIX, which also writes HI/LO.
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   start        request an operation (sampled only while not busy)
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   porta/portb  multiplicand/dividend, multiplier/divisor
//   busy         high during CALC and FIX
//   done         one-cycle pulse when hi/lo hold a new result
//   hi/lo        HI/LO registers
module muldiv_unit #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] porta,
  input  logic [WORD_W-1:0] portb,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 2 * WORD_W;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;      // negate product / quotient
  logic               r_neg_r;      // negate remainder
  logic [WORD_W-1:0]  r_opnd;       // multiplicand magnitude or divisor magnitude
  logic [WORD_W-1:0]  r_porta;      // original dividend for divide-by-zero
  logic [ACC_W-1:0]   r_acc;        // product, or {remainder, quotient}
  logic               r_busy;
  logic               r_done;
  logic [WORD_W-1:0]  r_hi;
  logic [WORD_W-1:0]  r_lo;

  // Operand preparation at accept
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WORD_W-1:0]  w_mag_a;
  logic [WORD_W-1:0]  w_mag_b;

  // Iteration datapath
  logic [WORD_W:0]    w_mul_sum;
  logic [ACC_W-1:0]   w_mul_acc;
  logic [WORD_W:0]    w_div_shift;
  logic               w_div_ge;
  logic [WORD_W-1:0]  w_div_diff;
  logic [WORD_W-1:0]  w_div_rem;
  logic [ACC_W-1:0]   w_div_acc;

  // Sign fix-up
  logic [ACC_W-1:0]   w_prod;
  logic [WORD_W-1:0]  w_quo;
  logic [WORD_W-1:0]  w_rem;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_CALC;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Magnitudes; op[0] selects the signed variants
  always_comb begin
    w_a_neg = op[0] & porta[WORD_W-1];
    w_b_neg = op[0] & portb[WORD_W-1];
    w_mag_a = w_a_neg ? (~porta + 1'b1) : porta;
    w_mag_b = w_b_neg ? (~portb + 1'b1) : portb;
  end

  // One shift-add or restoring-divide step
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[ACC_W-1:WORD_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_acc   = {w_mul_sum, r_acc[WORD_W-1:1]};
    w_div_shift = {r_acc[ACC_W-1:WORD_W], r_acc[WORD_W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // When ge holds the difference is below the divisor, so WORD_W bits suffice
    w_div_diff  = w_div_shift[WORD_W-1:0] - r_opnd;
    w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WORD_W-1:0];
    w_div_acc   = {w_div_rem, r_acc[WORD_W-2:0], w_div_ge};
  end

  // Two's-complement sign application for FIX
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg_q ? (~r_acc[WORD_W-1:0] + 1'b1) : r_acc[WORD_W-1:0];
    w_rem  = r_neg_r ? (~r_acc[ACC_W-1:WORD_W] + 1'b1) : r_acc[ACC_W-1:WORD_W];
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_porta  <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= op[1];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_porta  <= porta;
        // Multiply adds the multiplicand; divide subtracts the divisor
        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
        r_acc    <= {{WORD_W{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end
      if (r_state == S_FIX) begin
        if (r_is_div) begin
          if (r_opnd == '0) begin
            r_hi <= r_porta;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end else begin
          r_hi <= w_prod[ACC_W-1:WORD_W];
          r_lo <= w_prod[WORD_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, control
// sequences (ignored start, mid-operation reset, back-to-back) and random
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] porta;
  logic [31:0] portb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WORD_W(32)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .porta (porta),
    .portb (portb),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MIPS HI/LO semantics from plain integer arithmetic; returns {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: res = ua * ub;
      2'b01: res = sa * sb;
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {32'(sr), 32'(sq)};
        end
      end
    endcase
    return res;
  endfunction

  // Launch one operation (call #1 after an edge) and follow it to done.
  // lat counts cycles from the accept edge, the cycle after it being 1.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, output logic [31:0] ghi, output logic [31:0] glo,
                       output int lat, output int bcnt);
    op    = o;
    porta = a;
    portb = b;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      if (lat == 1) begin
        porta = $urandom;
        portb = $urandom;
      end
      if (poke && lat == 5) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        porta = $urandom;
        portb = $urandom;
      end
      if (poke && lat == 6) start = 1'b0;
      @(posedge CLK);
      #1;
      lat++;
    end
    ghi = hi;
    glo = lo;
  endtask

  task automatic run_and_check(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input bit poke);
    logic [31:0] ghi, glo;
    logic [63:0] exp;
    int          lat, bcnt;
    do_op(o, a, b, poke, ghi, glo, lat, bcnt);
    exp = ref_model(o, a, b);
    check_eq("hi", {32'd0, ghi}, {32'd0, exp[63:32]});
    check_eq("lo", {32'd0, glo}, {32'd0, exp[31:0]});
    check_eq("latency", 64'(lat), 64'd34);
    check_eq("busy_cycles", 64'(bcnt), 64'd33);
  endtask

  logic [1:0]  d_op [5] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10};
  logic [31:0] d_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064};
  logic [31:0] d_b  [5] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
  logic [63:0] d_exp[5] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1,
                            64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                            64'h0000_0064_FFFF_FFFF};

  initial begin
    logic [31:0] ghi, glo, hold_hi, hold_lo, ra, rb;
    logic [63:0] exp;
    logic [1:0]  ro;
    int          lat, bcnt, seen_done, seen_busy;

    RST   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    porta = '0;
    portb = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Directed cases with hand-computed results and timing
    for (int i = 0; i < 5; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], 1'b0, ghi, glo, lat, bcnt);
      check_eq("dir_result", {ghi, glo}, d_exp[i]);
      check_eq("dir_latency", 64'(lat), 64'd34);
      check_eq("dir_busy_cycles", 64'(bcnt), 64'd33);
      @(posedge CLK);
      #1;
      check_eq("done_pulse", {63'd0, done}, 64'd0);
      check_eq("hold", {hi, lo}, d_exp[i]);
    end

    // start with different operands while busy must be ignored
    run_and_check(2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    run_and_check(2'b11, 32'h8765_4321, 32'h0000_0013, 1'b1);
    @(posedge CLK);
    #1;

    // Reset in the middle of CALC aborts without a done pulse
    hold_hi = hi;
    hold_lo = lo;
    check_eq("pre_rst_nonzero", {63'd0, (hold_hi != 0) || (hold_lo != 0)}, 64'd1);
    op    = 2'b00;
    porta = 32'hDEAD_BEEF;
    portb = 32'h0000_1001;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check_eq("calc_busy", {63'd0, busy}, 64'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    RST = 1'b0;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    check_eq("abort_no_done", 64'(seen_done), 64'd0);
    check_eq("abort_no_busy", 64'(seen_busy), 64'd0);

    // Back-to-back: second start issued in the DONE cycle
    run_and_check(2'b00, 32'h0001_0000, 32'h0003_0000, 1'b0);
    run_and_check(2'b10, 32'hFFFF_FFF0, 32'h0000_0007, 1'b0);
    run_and_check(2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0);

    // Random operations, with zero and small divisors favoured
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op(ro, ra, rb, 1'b0, ghi, glo, lat, bcnt);
      exp = ref_model(ro, ra, rb);
      check_eq("rnd_result", {ghi, glo}, exp);
      check_eq("rnd_latency", 64'(lat), 64'd34);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
